// File: rtl/ldm_pkg.sv
// rtl/ldm_pkg.sv - shared types and constants for the LDM/STM multi-register sequencer
package ldm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RDREG,
    S_MREQ,
    S_MWAIT,
    S_WRREG,
    S_WB,
    S_DONE
  } ldm_state_t;

  // Addressing modes indexed by {p_bit, u_bit}
  localparam logic [1:0] MODE_DA = 2'b00;
  localparam logic [1:0] MODE_IA = 2'b01;
  localparam logic [1:0] MODE_DB = 2'b10;
  localparam logic [1:0] MODE_IB = 2'b11;

  localparam int unsigned DEF_WORD_BYTES = 4;

endpackage

// File: rtl/lowest_set_bit.sv
// rtl/lowest_set_bit.sv - 16-bit priority encoder returning the lowest set bit index
module lowest_set_bit (
  input  logic [15:0] bits_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Scan from the top so the lowest set bit is the last one to win
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (bits_i[i]) begin
        idx_o = 4'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// rtl/ldm_stm_sequencer.sv - walks a register list, moving registers between register file and memory
module ldm_stm_sequencer
  import ldm_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DEF_WORD_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic        p_bit_i,
  input  logic        u_bit_i,
  input  logic        wback_i,
  input  logic [3:0]  rn_i,
  input  logic [31:0] base_i,
  input  logic [15:0] reg_list_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  rf_ra_o,
  input  logic [31:0] rf_rd_i,
  output logic [3:0]  rf_wa_o,
  output logic [31:0] rf_wd_o,
  output logic        rf_we_o,
  output logic        pc_load_o
);

  localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

  ldm_state_t  state_q;
  logic [15:0] list_q;
  logic        load_q, p_q, u_q, wback_q, rn_in_list_q, wd_held_q;
  logic [3:0]  rn_q, rf_wa_q;
  logic [31:0] base_q, addr_q, final_q, wdata_q, rf_wd_q;
  logic        rf_we_q, pc_load_q;

  logic [3:0]  idx;
  logic        any;
  logic [15:0] list_d;
  logic [4:0]  cnt;
  logic [31:0] span, start_addr, final_d;

  lowest_set_bit u_lsb (
    .bits_i (list_q),
    .idx_o  (idx),
    .any_o  (any)
  );

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + {4'b0, list_q[i]};
    span    = 32'(cnt) * STRIDE;
    final_d = u_q ? base_q + span : base_q - span;
    case ({p_q, u_q})
      MODE_IA: start_addr = base_q;
      MODE_IB: start_addr = base_q + STRIDE;
      MODE_DA: start_addr = base_q - span + STRIDE;
      MODE_DB: start_addr = base_q - span;
      default: start_addr = base_q;
    endcase
    list_d = list_q & ~(16'h1 << idx);
  end

  // Request signals decode straight from state so an async reset drops them at once
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign mem_req_o   = (state_q == S_MREQ);
  assign mem_we_o    = mem_req_o & ~load_q;
  assign mem_addr_o  = mem_req_o ? addr_q : '0;
  assign mem_wdata_o = mem_we_o ? (wd_held_q ? wdata_q : rf_rd_i) : '0;
  assign rf_ra_o     = (state_q == S_RDREG) ? idx : '0;
  assign rf_wa_o     = rf_wa_q;
  assign rf_wd_o     = rf_wd_q;
  assign rf_we_o     = rf_we_q;
  assign pc_load_o   = pc_load_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      list_q       <= '0;
      load_q       <= 1'b0;
      p_q          <= 1'b0;
      u_q          <= 1'b0;
      wback_q      <= 1'b0;
      rn_in_list_q <= 1'b0;
      wd_held_q    <= 1'b0;
      rn_q         <= '0;
      base_q       <= '0;
      addr_q       <= '0;
      final_q      <= '0;
      wdata_q      <= '0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
      rf_we_q      <= 1'b0;
      pc_load_q    <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      pc_load_q <= 1'b0;
      rf_wa_q   <= '0;
      rf_wd_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            list_q       <= reg_list_i;
            base_q       <= base_i;
            rn_q         <= rn_i;
            load_q       <= is_load_i;
            p_q          <= p_bit_i;
            u_q          <= u_bit_i;
            wback_q      <= wback_i;
            rn_in_list_q <= reg_list_i[rn_i];
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          addr_q  <= start_addr;
          final_q <= final_d;
          if (!any)        state_q <= S_DONE;
          else if (load_q) state_q <= S_MREQ;
          else             state_q <= S_RDREG;
        end
        S_RDREG: state_q <= S_MREQ;
        S_MREQ: begin
          if (mem_ready_i) begin
            addr_q    <= addr_q + STRIDE;
            wd_held_q <= 1'b0;
            if (load_q) begin
              state_q <= S_MWAIT;
            end else begin
              list_q <= list_d;
              if (list_d != '0) begin
                state_q <= S_RDREG;
              end else if (wback_q) begin
                state_q   <= S_WB;
                rf_we_q   <= 1'b1;
                rf_wa_q   <= rn_q;
                rf_wd_q   <= final_q;
                pc_load_q <= (rn_q == 4'hF);
              end else begin
                state_q <= S_DONE;
              end
            end
          end else if (!load_q && !wd_held_q) begin
            // Register read data is only valid for one cycle; keep it for a stalled store
            wdata_q   <= rf_rd_i;
            wd_held_q <= 1'b1;
          end
        end
        S_MWAIT: begin
          if (mem_rvalid_i) begin
            rf_we_q   <= 1'b1;
            rf_wa_q   <= idx;
            rf_wd_q   <= mem_rdata_i;
            pc_load_q <= (idx == 4'hF);
            list_q    <= list_d;
            state_q   <= S_WRREG;
          end
        end
        S_WRREG: begin
          if (any) begin
            state_q <= S_MREQ;
          end else if (wback_q && !rn_in_list_q) begin
            state_q   <= S_WB;
            rf_we_q   <= 1'b1;
            rf_wa_q   <= rn_q;
            rf_wd_q   <= final_q;
            pc_load_q <= (rn_q == 4'hF);
          end else begin
            state_q <= S_DONE;
          end
        end
        S_WB:    state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb/tb_ldm_stm_sequencer.sv - scoreboard bench for ldm_stm_sequencer
module tb_ldm_stm_sequencer;

  logic        clk, rst_n, start, is_load, p_bit, u_bit, wback;
  logic [3:0]  rn;
  logic [31:0] base;
  logic [15:0] reg_list;
  logic        busy, done, mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd;
  logic        rf_we, pc_load;

  typedef struct {
    int          kind;  // 0 = memory accept, 1 = register write, 2 = done
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] rf[16];
  logic [3:0]  ra_s;
  int          n_cmp = 0, n_bad = 0, cyc = 0, ready_delay = 0, wait_cnt = 0;
  bit          rv_pend = 0;

  ldm_stm_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .is_load_i    (is_load),
    .p_bit_i      (p_bit),
    .u_bit_i      (u_bit),
    .wback_i      (wback),
    .rn_i         (rn),
    .base_i       (base),
    .reg_list_i   (reg_list),
    .busy_o       (busy),
    .done_o       (done),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_ready_i  (mem_ready),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .rf_ra_o      (rf_ra),
    .rf_rd_i      (rf_rd),
    .rf_wa_o      (rf_wa),
    .rf_wd_o      (rf_wd),
    .rf_we_o      (rf_we),
    .pc_load_o    (pc_load)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  task automatic push_ev(input int k, input logic [31:0] a, input logic [31:0] b, input logic c);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    e.c    = c;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic ld, input logic p, input logic u, input logic wb,
                     input logic [3:0] r, input logic [31:0] b, input logic [15:0] l, input int lat);
    @(negedge clk);
    is_load  = ld;
    p_bit    = p;
    u_bit    = u;
    wback    = wb;
    rn       = r;
    base     = b;
    reg_list = l;
    start    = 1'b1;
    if (lat >= 0) push_ev(2, 32'(cyc + lat), 32'h0, 1'b0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d expected events left, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Memory: ready after ready_delay stalled cycles, load data one cycle after acceptance
  initial begin
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (rv_pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (ld_q.size() != 0) ? ld_q.pop_front() : 32'hDEAD_BEEF;
        rv_pend    = 1'b0;
      end
      if (mem_req) begin
        if (wait_cnt >= ready_delay) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          if (!mem_we) rv_pend = 1'b1;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Register file with one-cycle synchronous read
  initial begin
    rf_rd = '0;
    forever begin
      @(negedge clk);
      ra_s = rf_ra;
      @(posedge clk);
      #1;
      rf_rd = rf[ra_s];
    end
  end

  // Monitor / scoreboard
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (mem_req && mem_ready) begin
          if (exp_q.size() == 0 || exp_q[0].kind != 0) unexpected("mem_accept");
          else begin
            e = exp_q.pop_front();
            chk("mem_we", 32'(mem_we), 32'(e.c));
            chk("mem_addr", mem_addr, e.a);
            chk("mem_wdata", mem_wdata, e.b);
          end
        end else if (mem_req && exp_q.size() != 0 && exp_q[0].kind == 0) begin
          chk("stall_addr", mem_addr, exp_q[0].a);
          chk("stall_wdata", mem_wdata, exp_q[0].b);
        end
        if (rf_we) begin
          if (exp_q.size() == 0 || exp_q[0].kind != 1) unexpected("rf_write");
          else begin
            e = exp_q.pop_front();
            chk("rf_wa", 32'(rf_wa), e.a);
            chk("rf_wd", rf_wd, e.b);
            chk("pc_load", 32'(pc_load), 32'(e.c));
          end
        end else if (pc_load) begin
          unexpected("pc_load_without_we");
        end
        if (done) begin
          if (exp_q.size() == 0 || exp_q[0].kind != 2) unexpected("done");
          else begin
            e = exp_q.pop_front();
            chk("done_cycle", 32'(cyc), e.a);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; p_bit = 1'b0; u_bit = 1'b0;
    wback = 1'b0; rn = '0; base = '0; reg_list = '0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h100 + 32'(i);
    rf[0] = 32'hA;
    rf[2] = 32'hB;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rf_ra", 32'(rf_ra), 32'h0);
    chk("rst_rf_wa", 32'(rf_wa), 32'h0);
    chk("rst_rf_wd", rf_wd, 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'h0);
    chk("rst_pc_load", 32'(pc_load), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // STM IA, writeback rn=3
    push_ev(0, 32'h1000, 32'hA, 1'b1);
    push_ev(0, 32'h1004, 32'hB, 1'b1);
    push_ev(1, 32'd3, 32'h1008, 1'b0);
    run(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h1000, 16'h0005, 7);
    wait_drain("stm_ia");

    // LDM DB including r15
    ld_q.push_back(32'd1); ld_q.push_back(32'd2); ld_q.push_back(32'd3);
    push_ev(0, 32'h1FF4, 32'h0, 1'b0); push_ev(1, 32'd0, 32'd1, 1'b0);
    push_ev(0, 32'h1FF8, 32'h0, 1'b0); push_ev(1, 32'd1, 32'd2, 1'b0);
    push_ev(0, 32'h1FFC, 32'h0, 1'b0); push_ev(1, 32'd15, 32'd3, 1'b1);
    run(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 32'h2000, 16'h8003, 11);
    wait_drain("ldm_db");

    // LDM IB with rn in list: loaded value wins, no writeback
    ld_q.push_back(32'h11); ld_q.push_back(32'h22);
    push_ev(0, 32'h4004, 32'h0, 1'b0); push_ev(1, 32'd1, 32'h11, 1'b0);
    push_ev(0, 32'h4008, 32'h0, 1'b0); push_ev(1, 32'd2, 32'h22, 1'b0);
    run(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 32'h4000, 16'h0006, 8);
    wait_drain("ldm_rn_in_list");

    // STM DA with 3-cycle ready stall and a start pulse while busy
    ready_delay = 3;
    push_ev(0, 32'h4FFC, 32'hB, 1'b1);
    push_ev(0, 32'h5000, 32'h104, 1'b1);
    push_ev(1, 32'd13, 32'h4FF8, 1'b0);
    run(1'b0, 1'b0, 1'b0, 1'b1, 4'd13, 32'h5000, 16'h0014, 13);
    repeat (3) @(negedge clk);
    is_load = 1'b1; reg_list = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("stm_stall");
    ready_delay = 0;

    // Empty list, start held across done: accepted again only after DONE
    @(negedge clk);
    is_load = 1'b0; wback = 1'b1; reg_list = 16'h0; rn = 4'd2; base = 32'h6000; start = 1'b1;
    push_ev(2, 32'(cyc + 2), 32'h0, 1'b0);
    push_ev(2, 32'(cyc + 5), 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_drain("empty_list");

    // Reset while the second LDM transfer is stalled
    ready_delay = 2;
    ld_q.push_back(32'h77);
    push_ev(0, 32'h3000, 32'h0, 1'b0);
    push_ev(1, 32'd0, 32'h77, 1'b0);
    run(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'h3000, 16'h0007, -1);
    wait_drain("pre_reset");
    for (int i = 0; i < 50; i++) begin
      if (mem_req) break;
      @(negedge clk);
    end
    chk("second_req_seen", 32'(mem_req), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rf_we", 32'(rf_we), 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    rv_pend = 1'b0; wait_cnt = 0; ready_delay = 0; ld_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean LDM IA after reset, writeback rn=7
    ld_q.push_back(32'h55); ld_q.push_back(32'h66);
    push_ev(0, 32'h3000, 32'h0, 1'b0); push_ev(1, 32'd0, 32'h55, 1'b0);
    push_ev(0, 32'h3004, 32'h0, 1'b0); push_ev(1, 32'd1, 32'h66, 1'b0);
    push_ev(1, 32'd7, 32'h3008, 1'b0);
    run(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 32'h3000, 16'h0003, 9);
    wait_drain("ldm_after_reset");
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
